// File: rtl/wash_program_controller.sv
// Program sequencer for the washing machine: latches quick/normal/heavy, starts the machine and times wash/rinse/spin.
// Define WPC_PAUSE_EN to add a pause input that freezes phase timing inside the timed states.
module wash_program_controller #(
  parameter int TW          = 8,
  parameter int WASH_QUICK  = 8,
  parameter int WASH_NORMAL = 16,
  parameter int WASH_HEAVY  = 32,
  parameter int SPIN_T      = 12,
  parameter int WDOG_T      = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] prog_sel,
  input  logic       user_start,
  input  logic       user_abort,
`ifdef WPC_PAUSE_EN
  input  logic       pause,
`endif
  input  logic       door_lock,
  input  logic       soap_wash,
  input  logic       water_wash,
  input  logic       motor_on,
  input  logic       drain_value_on,
  input  logic       done,
  output logic       machine_start,
  output logic       cycle_timeout,
  output logic       spin_timeout,
  output logic       busy,
  output logic       prog_done,
  output logic       err,
  output logic [1:0] prog_q
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_RUN, ST_WASH, ST_WAIT_R, ST_RINSE, ST_WAIT_S, ST_SPIN, ST_COMPLETE, ST_ERROR
  } state_t;

  // Zero durations are promoted to one cycle so every phase still produces a timeout.
  localparam logic [TW-1:0] D_QUICK  = (WASH_QUICK  < 1) ? TW'(1) : TW'(WASH_QUICK);
  localparam logic [TW-1:0] D_NORMAL = (WASH_NORMAL < 1) ? TW'(1) : TW'(WASH_NORMAL);
  localparam logic [TW-1:0] D_HEAVY  = (WASH_HEAVY  < 1) ? TW'(1) : TW'(WASH_HEAVY);
  localparam logic [TW-1:0] D_SPIN   = (SPIN_T      < 1) ? TW'(1) : TW'(SPIN_T);
  localparam int            WDW      = (WDOG_T > 1) ? $clog2(WDOG_T + 1) : 1;
  localparam logic [WDW-1:0] WD_LIM  = WDW'((WDOG_T > 1) ? WDOG_T - 1 : 0);

  state_t          state, next;
  logic [TW-1:0]   timer, load_val, dw, dw_half, dr;
  logic [WDW-1:0]  wdog;
  logic            wash_on, rinse_on, spin_on;
  logic            paused, timed, frozen, watched, wdog_hit;

`ifdef WPC_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign wash_on  = soap_wash & motor_on;
  assign rinse_on = water_wash & motor_on;
  assign spin_on  = drain_value_on & motor_on;
  assign timed    = (state == ST_WASH) || (state == ST_RINSE) || (state == ST_SPIN);
  assign watched  = (state == ST_RUN) || (state == ST_WAIT_R) || (state == ST_WAIT_S);
  assign frozen   = paused & timed;
  assign wdog_hit = watched && (wdog == WD_LIM);

  assign machine_start = (state == ST_RUN) || (state == ST_WAIT_R) || (state == ST_WAIT_S) || timed;
  assign busy          = (state != ST_IDLE);
  assign err           = (state == ST_ERROR);

  always_comb begin
    dw = D_NORMAL;
    case (prog_q)
      2'b00:   dw = D_QUICK;
      2'b10:   dw = D_HEAVY;
      default: dw = D_NORMAL;
    endcase
    dw_half = dw >> 1;
    dr      = (dw_half == '0) ? TW'(1) : dw_half;
  end

  // Transitions; user_abort overrides everything, door loss overrides phase progress.
  always_comb begin
    next = state;
    case (state)
      ST_IDLE:     if (user_start) next = ST_RUN;
      ST_RUN:      if (wash_on) next = ST_WASH;
                   else if (wdog_hit) next = ST_ERROR;
      ST_WASH:     if (!door_lock) next = ST_ERROR;
                   else if (!frozen && !wash_on) next = ST_WAIT_R;
      ST_WAIT_R:   if (rinse_on) next = ST_RINSE;
                   else if (wdog_hit) next = ST_ERROR;
      ST_RINSE:    if (!door_lock) next = ST_ERROR;
                   else if (!frozen && !rinse_on) next = ST_WAIT_S;
      ST_WAIT_S:   if (spin_on) next = ST_SPIN;
                   else if (wdog_hit) next = ST_ERROR;
      ST_SPIN:     if (!door_lock) next = ST_ERROR;
                   else if (!frozen && spin_timeout && done) next = ST_COMPLETE;
      ST_COMPLETE: if (!user_start) next = ST_IDLE;
      ST_ERROR:    next = ST_ERROR;
      default:     next = ST_IDLE;
    endcase
    if (user_abort) next = ST_IDLE;
  end

  always_comb begin
    load_val = '0;
    case (next)
      ST_WASH:  load_val = dw - TW'(1);
      ST_RINSE: load_val = dr - TW'(1);
      ST_SPIN:  load_val = D_SPIN - TW'(1);
      default:  load_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      timer         <= '0;
      wdog          <= '0;
      cycle_timeout <= 1'b0;
      spin_timeout  <= 1'b0;
      prog_done     <= 1'b0;
      prog_q        <= 2'b00;
    end else begin
      state     <= next;
      prog_done <= (next == ST_COMPLETE) && (state != ST_COMPLETE);
      if (user_abort) prog_q <= 2'b00;
      else if (state == ST_IDLE && user_start) prog_q <= prog_sel;
      // Any state change (including abort) reloads the timer and drops held timeouts.
      if (user_abort || next != state) begin
        timer         <= load_val;
        wdog          <= '0;
        cycle_timeout <= 1'b0;
        spin_timeout  <= 1'b0;
      end else begin
        if (timed && !frozen && timer != '0) timer <= timer - TW'(1);
        if ((state == ST_WASH || state == ST_RINSE) && !frozen && timer == '0 && !cycle_timeout)
          cycle_timeout <= 1'b1;
        if (state == ST_SPIN && !frozen && timer == '0 && !spin_timeout)
          spin_timeout <= 1'b1;
        if (watched) wdog <= wdog + WDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wash_program_controller.sv
// Self-checking bench for wash_program_controller; phase timeout instants are predicted into a queue.
// Build with WPC_PAUSE_EN defined to include the pause scenario.
module tb_wash_program_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] prog_sel = 2'b00;
  logic       user_start = 1'b0;
  logic       user_abort = 1'b0;
`ifdef WPC_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       door_lock = 1'b1;
  logic       soap_wash = 1'b0;
  logic       water_wash = 1'b0;
  logic       motor_on = 1'b0;
  logic       drain_value_on = 1'b0;
  logic       done = 1'b0;
  logic       machine_start, cycle_timeout, spin_timeout, busy, prog_done, err;
  logic [1:0] prog_q;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  wash_program_controller dut (
    .clk(clk), .reset(reset), .prog_sel(prog_sel), .user_start(user_start), .user_abort(user_abort),
`ifdef WPC_PAUSE_EN
    .pause(pause),
`endif
    .door_lock(door_lock), .soap_wash(soap_wash), .water_wash(water_wash), .motor_on(motor_on),
    .drain_value_on(drain_value_on), .done(done), .machine_start(machine_start),
    .cycle_timeout(cycle_timeout), .spin_timeout(spin_timeout), .busy(busy),
    .prog_done(prog_done), .err(err), .prog_q(prog_q)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_phase(input int kind);
    soap_wash      = (kind == 1);
    water_wash     = (kind == 2);
    drain_value_on = (kind == 3);
    motor_on       = (kind != 0);
  endtask

  // The next rising edge samples the phase; its timeout is due dur edges after that.
  task automatic drive_phase(input int kind, input int dur);
    set_phase(kind);
    exp_q.push_back(32'(cyc + 1 + dur));
  endtask

  task automatic wait_timeout(input bit spin, input int limit, output int obs);
    obs = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((spin ? spin_timeout : cycle_timeout) === 1'b1) begin
        obs = cyc;
        break;
      end
    end
  endtask

  task automatic start_prog(input logic [1:0] p);
    prog_sel   = p;
    user_start = 1'b1;
    tick(1);
  endtask

  task automatic pulse_abort();
    user_abort = 1'b1;
    tick(1);
    user_abort = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    tick(2);
    n_cmp++;
    if ({machine_start, cycle_timeout, spin_timeout, busy, prog_done, err, prog_q} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: got ms=%b ct=%b st=%b busy=%b pd=%b err=%b pq=%b, required all 0",
               machine_start, cycle_timeout, spin_timeout, busy, prog_done, err, prog_q);
    end
    reset = 1'b0;
    tick(1);
    n_cmp++;
    if (busy !== 1'b0 || machine_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b ms=%b, required 0 0", busy, machine_start);
    end
  endtask

  task automatic test_quick();
    logic [31:0] e;
    int obs;
    start_prog(2'b00);
    n_cmp++;
    if (busy !== 1'b1 || machine_start !== 1'b1 || prog_q !== 2'b00) begin
      n_fail++;
      $display("FAIL quick_start: got busy=%b ms=%b pq=%b, required 1 1 00", busy, machine_start, prog_q);
    end
    tick(3);
    drive_phase(1, 8);
    wait_timeout(1'b0, 40, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== int'(e)) begin n_fail++; $display("FAIL quick_wash: timeout at edge %0d, required %0d", obs, e); end
    tick(2);
    n_cmp++;
    if (cycle_timeout !== 1'b1) begin n_fail++; $display("FAIL quick_hold: cycle_timeout=%b, required 1", cycle_timeout); end
    set_phase(0);
    tick(1);
    n_cmp++;
    if (cycle_timeout !== 1'b0) begin n_fail++; $display("FAIL quick_clear: cycle_timeout=%b, required 0", cycle_timeout); end
    tick(2);
    drive_phase(2, 4);
    wait_timeout(1'b0, 40, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== int'(e)) begin n_fail++; $display("FAIL quick_rinse: timeout at edge %0d, required %0d", obs, e); end
    set_phase(0);
    tick(1);
    drive_phase(3, 12);
    wait_timeout(1'b1, 40, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== int'(e)) begin n_fail++; $display("FAIL quick_spin: spin_timeout at edge %0d, required %0d", obs, e); end
    tick(2);
    done = 1'b1;
    tick(1);
    n_cmp++;
    if (prog_done !== 1'b1 || spin_timeout !== 1'b0 || machine_start !== 1'b0) begin
      n_fail++;
      $display("FAIL quick_done: got pd=%b st=%b ms=%b, required 1 0 0", prog_done, spin_timeout, machine_start);
    end
    done = 1'b0;
    set_phase(0);
    tick(1);
    n_cmp++;
    if (prog_done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL quick_complete_hold: got pd=%b busy=%b, required 0 1", prog_done, busy);
    end
    user_start = 1'b0;
    tick(1);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL quick_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_durations();
    logic [1:0]  progs[2];
    int          durs[2];
    logic [31:0] e;
    int          obs;
    progs = '{2'b10, 2'b11};
    durs  = '{32, 16};
    for (int i = 0; i < 2; i++) begin
      start_prog(progs[i]);
      user_start = 1'b0;
      tick(1);
      prog_sel = ~progs[i];
      drive_phase(1, durs[i]);
      wait_timeout(1'b0, 80, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== int'(e)) begin n_fail++; $display("FAIL dur_wash prog=%b: timeout at edge %0d, required %0d", progs[i], obs, e); end
      set_phase(0);
      tick(1);
      prog_sel = progs[i] ^ 2'b01;
      drive_phase(2, durs[i] / 2);
      wait_timeout(1'b0, 80, obs);
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== int'(e)) begin n_fail++; $display("FAIL dur_rinse prog=%b: timeout at edge %0d, required %0d", progs[i], obs, e); end
      set_phase(0);
      pulse_abort();
      n_cmp++;
      if (busy !== 1'b0 || prog_q !== 2'b00 || cycle_timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL dur_abort: got busy=%b pq=%b ct=%b, required 0 00 0", busy, prog_q, cycle_timeout);
      end
    end
  endtask

  task automatic test_door();
    start_prog(2'b01);
    user_start = 1'b0;
    tick(1);
    set_phase(1);
    tick(5);
    door_lock = 1'b0;
    tick(1);
    n_cmp++;
    if (err !== 1'b1 || machine_start !== 1'b0 || cycle_timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL door_error: got err=%b ms=%b ct=%b busy=%b, required 1 0 0 1", err, machine_start, cycle_timeout, busy);
    end
    door_lock = 1'b1;
    set_phase(0);
    tick(3);
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL door_stay: err=%b, required 1", err); end
    pulse_abort();
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL door_abort: got err=%b busy=%b, required 0 0", err, busy);
    end
  endtask

  task automatic test_watchdog();
    logic [31:0] e;
    int obs;
    start_prog(2'b00);
    user_start = 1'b0;
    exp_q.push_back(32'(cyc + 64));
    obs = -1;
    for (int i = 0; i < 100; i++) begin
      if (err === 1'b1) begin obs = cyc; break; end
      @(negedge clk);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== int'(e)) begin n_fail++; $display("FAIL watchdog: err rose at edge %0d, required %0d", obs, e); end
    n_cmp++;
    if (machine_start !== 1'b0) begin n_fail++; $display("FAIL watchdog_ms: machine_start=%b, required 0", machine_start); end
    pulse_abort();
  endtask

  task automatic test_abort_mid();
    start_prog(2'b01);
    user_start = 1'b0;
    tick(2);
    set_phase(1);
    tick(3);
    user_abort = 1'b1;
    tick(1);
    n_cmp++;
    if (busy !== 1'b0 || machine_start !== 1'b0 || cycle_timeout !== 1'b0 || prog_q !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_mid: got busy=%b ms=%b ct=%b pq=%b, required 0 0 0 00", busy, machine_start, cycle_timeout, prog_q);
    end
    user_abort = 1'b0;
    set_phase(0);
    tick(2);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_stays_idle: busy=%b, required 0", busy); end
  endtask

  task automatic test_async_reset();
    start_prog(2'b00);
    user_start = 1'b0;
    set_phase(1);
    tick(10);
    set_phase(0);
    tick(2);
    set_phase(2);
    tick(6);
    set_phase(0);
    tick(2);
    set_phase(3);
    tick(4);
    n_cmp++;
    if (busy !== 1'b1 || machine_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got busy=%b ms=%b, required 1 1", busy, machine_start);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({machine_start, cycle_timeout, spin_timeout, busy, prog_done, err, prog_q} !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_async: got ms=%b ct=%b st=%b busy=%b pd=%b err=%b pq=%b, required all 0",
               machine_start, cycle_timeout, spin_timeout, busy, prog_done, err, prog_q);
    end
    @(negedge clk);
    reset = 1'b0;
    set_phase(0);
    tick(1);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: busy=%b, required 0", busy); end
  endtask

`ifdef WPC_PAUSE_EN
  task automatic test_pause();
    logic [31:0] e;
    int obs;
    start_prog(2'b01);
    user_start = 1'b0;
    tick(1);
    drive_phase(1, 26);
    tick(4);
    pause = 1'b1;
    tick(10);
    pause = 1'b0;
    wait_timeout(1'b0, 60, obs);
    e = exp_q.pop_front();
    n_cmp++;
    if (obs !== int'(e)) begin n_fail++; $display("FAIL pause_wash: timeout at edge %0d, required %0d", obs, e); end
    pause = 1'b1;
    tick(2);
    n_cmp++;
    if (cycle_timeout !== 1'b1) begin n_fail++; $display("FAIL pause_hold: ct=%b, required 1", cycle_timeout); end
    pulse_abort();
    pause = 1'b0;
    set_phase(0);
    n_cmp++;
    if (busy !== 1'b0 || cycle_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL pause_abort: got busy=%b ct=%b, required 0 0", busy, cycle_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_quick();
    test_durations();
    test_door();
    test_watchdog();
    test_abort_mid();
`ifdef WPC_PAUSE_EN
    test_pause();
`endif
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
